// File: rtl/switch_debouncer.sv
// Multi-channel switch debouncer with per-channel qualification FSM.
// Emits a registered clean level plus one-cycle rise/fall pulses.
module switch_debouncer #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             CLK_5_MHZ,
  input  logic             CPU_RESETN,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             any_change
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_LO,
    CHK_HI,
    IDLE_HI,
    CHK_LO
  } state_t;

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] sync;

  state_t          state_q [WIDTH];
  state_t          state_d [WIDTH];
  logic [CW-1:0]   cnt_q   [WIDTH];
  logic [CW-1:0]   cnt_d   [WIDTH];

  logic [WIDTH-1:0] clean_d;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_d;

  // Two-flop synchronizer per raw channel.
  always_ff @(posedge CLK_5_MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= raw_in;
      sync <= meta;
    end
  end

  // Per-channel next state: a level must hold DEBOUNCE_CYCLES+1 looks to flip.
  always_comb begin
    clean_d = clean_out;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
    end
    for (int i = 0; i < WIDTH; i++) begin
      unique case (state_q[i])
        IDLE_LO: begin
          if (sync[i]) begin
            state_d[i] = CHK_HI;
            cnt_d[i]   = '0;
          end
        end
        CHK_HI: begin
          if (!sync[i]) begin
            state_d[i] = IDLE_LO;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = IDLE_HI;
            cnt_d[i]   = '0;
            clean_d[i] = 1'b1;
            rise_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        IDLE_HI: begin
          if (!sync[i]) begin
            state_d[i] = CHK_LO;
            cnt_d[i]   = '0;
          end
        end
        CHK_LO: begin
          if (sync[i]) begin
            state_d[i] = IDLE_HI;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = IDLE_LO;
            cnt_d[i]   = '0;
            clean_d[i] = 1'b0;
            fall_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
      endcase
    end
  end

  // State, counters and registered outputs; any_change lines up with pulses.
  always_ff @(posedge CLK_5_MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= IDLE_LO;
        cnt_q[i]   <= '0;
      end
      clean_out  <= '0;
      rise_pulse <= '0;
      fall_pulse <= '0;
      any_change <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      clean_out  <= clean_d;
      rise_pulse <= rise_d;
      fall_pulse <= fall_d;
      any_change <= |(rise_d | fall_d);
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: reset, directed tables, corner
// sequences and random stimulus against a run-length model.
module tb_switch_debouncer;

  localparam int W = 3;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] raw_in = '0;
  logic [W-1:0] clean_out;
  logic [W-1:0] rise_pulse;
  logic [W-1:0] fall_pulse;
  logic         any_change;

  int checks = 0;
  int failures = 0;
  int rise_tot = 0;
  int fall_tot = 0;
  int any_tot = 0;

  logic [W-1:0] m_clean, m_rise, m_fall;
  logic         m_any;
  logic [W-1:0] h1, h2;
  int           run [W];

  typedef struct {
    logic [W-1:0] raw;
    int           hold;
    logic [W-1:0] clean;
    int           rises;
    int           falls;
  } phase_t;

  phase_t tbl [13];

  switch_debouncer #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .CLK_5_MHZ(clk),
    .CPU_RESETN(rst_n),
    .raw_in(raw_in),
    .clean_out(clean_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .any_change(any_change)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_clean = '0;
    m_rise  = '0;
    m_fall  = '0;
    m_any   = 1'b0;
    h1      = '0;
    h2      = '0;
    for (int c = 0; c < W; c++) run[c] = 0;
  endtask

  // A channel flips once it has seen D+1 consecutive samples that
  // differ from its clean level; samples reach it two edges late.
  task automatic model_edge(input logic [W-1:0] r);
    m_rise = '0;
    m_fall = '0;
    for (int c = 0; c < W; c++) begin
      if (h2[c] != m_clean[c]) begin
        run[c]++;
        if (run[c] == D + 1) begin
          m_clean[c] = ~m_clean[c];
          if (m_clean[c]) m_rise[c] = 1'b1;
          else m_fall[c] = 1'b1;
          run[c] = 0;
        end
      end else begin
        run[c] = 0;
      end
    end
    m_any = |(m_rise | m_fall);
    h2 = h1;
    h1 = r;
  endtask

  task automatic tick(input logic [W-1:0] r);
    raw_in = r;
    @(posedge clk);
    if (rst_n) model_edge(r);
    else model_reset();
    @(negedge clk);
    chk("model", 32'({clean_out, rise_pulse, fall_pulse, any_change}),
        32'({m_clean, m_rise, m_fall, m_any}));
    rise_tot += $countones(rise_pulse);
    fall_tot += $countones(fall_pulse);
    if (any_change) any_tot++;
  endtask

  task automatic rst_assert();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_async",
        32'({clean_out, rise_pulse, fall_pulse, any_change}), 32'(0));
  endtask

  initial begin
    int r0, f0, at, cnt;
    logic [W-1:0] cur;

    tbl[0]  = '{3'b010,  3, 3'b000, 0, 0};
    tbl[1]  = '{3'b000,  8, 3'b000, 0, 0};
    tbl[2]  = '{3'b011, 10, 3'b011, 2, 0};
    tbl[3]  = '{3'b001, 10, 3'b001, 0, 1};
    tbl[4]  = '{3'b100, 10, 3'b100, 1, 1};
    tbl[5]  = '{3'b000, 10, 3'b000, 0, 1};
    tbl[6]  = '{3'b111,  5, 3'b000, 0, 0};
    tbl[7]  = '{3'b111,  5, 3'b111, 3, 0};
    tbl[8]  = '{3'b000, 10, 3'b000, 0, 3};
    tbl[9]  = '{3'b001,  4, 3'b000, 0, 0};
    tbl[10] = '{3'b000,  8, 3'b000, 0, 0};
    tbl[11] = '{3'b001,  5, 3'b000, 0, 0};
    tbl[12] = '{3'b000, 10, 3'b000, 1, 1};

    raw_in = 3'b111;
    #1;
    rst_assert();
    for (int i = 0; i < 4; i++) begin
      tick(3'b111);
      chk("rst_hold",
          32'({clean_out, rise_pulse, fall_pulse, any_change}), 32'(0));
    end
    rst_n = 1'b1;
    at = -1;
    any_tot = 0;
    for (int i = 1; i <= 10; i++) begin
      tick(3'b111);
      if (rise_pulse != '0 && at < 0) at = i;
      if (i == 7) begin
        chk("rel_rise", 32'(rise_pulse), 32'(3'b111));
        chk("rel_clean", 32'(clean_out), 32'(3'b111));
        chk("rel_any", 32'(any_change), 32'(1));
      end
      if (i == 8) chk("rel_any_off", 32'(any_change), 32'(0));
    end
    chk("rel_rise_at", 32'(at), 32'(7));
    chk("rel_any_cnt", 32'(any_tot), 32'(1));
    for (int i = 0; i < 12; i++) tick(3'b000);

    foreach (tbl[p]) begin
      r0 = rise_tot;
      f0 = fall_tot;
      for (int i = 0; i < tbl[p].hold; i++) tick(tbl[p].raw);
      chk($sformatf("tbl%0d_clean", p), 32'(clean_out), 32'(tbl[p].clean));
      chk($sformatf("tbl%0d_rise", p), 32'(rise_tot - r0),
          32'(tbl[p].rises));
      chk($sformatf("tbl%0d_fall", p), 32'(fall_tot - f0),
          32'(tbl[p].falls));
    end

    for (int i = 1; i <= 8; i++) begin
      tick(3'b001);
      if (i < 7) chk("ch0_early", 32'(clean_out), 32'(3'b000));
      if (i == 7) begin
        chk("ch0_rise", 32'(rise_pulse), 32'(3'b001));
        chk("ch0_clean", 32'(clean_out), 32'(3'b001));
      end
      if (i == 8) begin
        chk("ch0_rise_off", 32'(rise_pulse), 32'(3'b000));
        chk("ch0_clean_hold", 32'(clean_out), 32'(3'b001));
      end
    end
    for (int i = 0; i < 12; i++) tick(3'b000);

    at = -1;
    cnt = 0;
    for (int i = 1; i <= 32; i++) begin
      if (i <= 20) cur = (((i - 1) / 2) % 2 == 0) ? 3'b100 : 3'b000;
      else cur = 3'b100;
      tick(cur);
      if (rise_pulse[2]) begin
        cnt++;
        if (at < 0) at = i;
      end
    end
    chk("bounce_rise_cnt", 32'(cnt), 32'(1));
    chk("bounce_rise_at", 32'(at), 32'(27));
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick(3'b000);
      if (fall_pulse[2]) cnt++;
    end
    chk("bounce_fall_cnt", 32'(cnt), 32'(1));

    for (int i = 0; i < 5; i++) tick(3'b001);
    rst_assert();
    r0 = rise_tot;
    for (int i = 0; i < 3; i++) tick(3'b001);
    chk("abort_no_pulse", 32'(rise_tot - r0), 32'(0));
    rst_n = 1'b1;
    at = -1;
    cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      tick(3'b001);
      if (rise_pulse[0]) begin
        cnt++;
        if (at < 0) at = i;
      end
    end
    chk("requal_cnt", 32'(cnt), 32'(1));
    chk("requal_at", 32'(at), 32'(7));
    chk("requal_clean", 32'(clean_out), 32'(3'b001));
    for (int i = 0; i < 12; i++) tick(3'b000);

    cur = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < W; c++)
        if ($urandom_range(5) == 0) cur[c] = ~cur[c];
      if (i == 1500) rst_assert();
      if (i == 1503) rst_n = 1'b1;
      tick(cur);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
